adder_seq_ctrl: RTL and testbench

Sequencing controller that reuses one narrow combinational adder slice, such as the 2-bit `adder` netlist, to perform WIDTH-bit additions over multiple cycles. It accepts operands over a valid/ready handshake and latches them. It then feeds the slice one CHUNK-bit digit per cycle, LSB first, keeping the inter-chunk carry in a register. It assembles the sum and returns it with the final carry over a second valid/ready handshake. It sits between a requesting datapath and the shared adder slice; the slice itself lives outside this block.

---
 rtl/adder_seq_ctrl.sv | 75 +++++++
 tb/tb_adder_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-cycle WIDTH-bit add, one CHUNK-bit digit per cycle through an external adder slice
module adder_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [CHUNK-1:0] dp_a,
   output logic [CHUNK-1:0] dp_b,
   output logic             dp_ci,
   input  logic [CHUNK-1:0] dp_sum,
   input  logic             dp_co
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_sh_d;
   logic             carry_q, cout_q;
   logic [CW-1:0]    cnt_q;
   logic             run;
   assign run       = state_q == RUN;
   assign sum_sh_d  = WIDTH'({dp_sum, sum_sh_q} >> CHUNK);
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign sum       = sum_sh_q;
   assign cout      = cout_q;
   assign dp_a      = run ? a_sh_q[CHUNK-1:0] : '0;
   assign dp_b      = run ? b_sh_q[CHUNK-1:0] : '0;
   assign dp_ci     = run & carry_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else
         case (state_q)
            IDLE: if (in_valid) begin
               a_sh_q  <= a;
               b_sh_q  <= b;
               carry_q <= cin;
               cnt_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               // slice result for the current digit enters at the top of the sum shifter
               a_sh_q   <= a_sh_q >> CHUNK;
               b_sh_q   <= b_sh_q >> CHUNK;
               sum_sh_q <= sum_sh_d;
               carry_q  <= dp_co;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  cout_q  <= dp_co;
                  state_q <= DONE;
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: scoreboard bench for adder_seq_ctrl with a behavioural 2-bit slice
module tb_adder_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [7:0] a, b, sum;
   logic [1:0] dp_a, dp_b, dp_sum;
   logic       dp_ci, dp_co;
   logic [8:0] sb[$];
   logic [8:0] exp_v;
   int         tests = 0, fails = 0;

   always #5 clk = ~clk;

   assign {dp_co, dp_sum} = {1'b0, dp_a} + {1'b0, dp_b} + {2'b0, dp_ci};

   adder_seq_ctrl #(.WIDTH(8), .CHUNK(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy), .dp_a(dp_a), .dp_b(dp_b),
      .dp_ci(dp_ci), .dp_sum(dp_sum), .dp_co(dp_co)
   );

   task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic c);
      a = aa; b = bb; cin = c; in_valid = 1'b1;
      if (in_ready) sb.push_back({1'b0, aa} + {1'b0, bb} + {8'b0, c});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      @(negedge clk); @(negedge clk);
      tests++; if ({in_ready, out_valid, busy, cout, dp_ci} !== 5'b10000) begin fails++; $display("FAIL reset_ctl got %b want 10000", {in_ready, out_valid, busy, cout, dp_ci}); end
      tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
      tests++; if ({dp_a, dp_b} !== 4'b0) begin fails++; $display("FAIL reset_dp got %b want 0000", {dp_a, dp_b}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      bit ok;
      out_ready = 1'b1;
      send(8'hB5, 8'h6E, 1'b0);
      tests++; if ({dp_a, dp_b, dp_ci} !== 5'b01100) begin fails++; $display("FAIL basic_dp0 got %b want 01100", {dp_a, dp_b, dp_ci}); end
      tests++; if ({busy, in_ready} !== 2'b10) begin fails++; $display("FAIL basic_busy got %b want 10", {busy, in_ready}); end
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid edge %0d got %b want 0", k, out_valid); end
      end
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency got out_valid=%b want 1 after edge 4", out_valid); end
      wait_valid(ok);
      exp_v = sb.pop_front();
      tests++; if ({cout, sum} !== exp_v || exp_v !== 9'h123) begin fails++; $display("FAIL basic_result got %h want %h", {cout, sum}, exp_v); end
      @(negedge clk);
      tests++; if ({in_ready, out_valid, busy} !== 3'b100) begin fails++; $display("FAIL basic_idle got %b want 100", {in_ready, out_valid, busy}); end
   endtask

   task automatic test_ripple;
      bit ok;
      out_ready = 1'b1;
      send(8'hFF, 8'h00, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tests++; if (dp_ci !== 1'b1) begin fails++; $display("FAIL ripple_ci chunk %0d got %b want 1", k, dp_ci); end
         @(negedge clk);
      end
      wait_valid(ok);
      tests++; if (!ok) begin fails++; $display("FAIL ripple_timeout got no out_valid want out_valid"); end
      exp_v = sb.pop_front();
      tests++; if ({cout, sum} !== exp_v) begin fails++; $display("FAIL ripple_result got %h want %h", {cout, sum}, exp_v); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      bit ok;
      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b0);
      wait_valid(ok);
      tests++; if (!ok) begin fails++; $display("FAIL bp_timeout got no out_valid want out_valid"); end
      for (int k = 0; k < 5; k++) begin
         in_valid = (k == 2); a = 8'hFF; b = 8'hFF; cin = 1'b1;
         tests++; if ({out_valid, in_ready} !== 2'b10) begin fails++; $display("FAIL bp_ctl cycle %0d got %b want 10", k, {out_valid, in_ready}); end
         tests++; if ({cout, sum} !== sb[0]) begin fails++; $display("FAIL bp_hold cycle %0d got %h want %h", k, {cout, sum}, sb[0]); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      exp_v = sb.pop_front();
      tests++; if ({cout, sum} !== exp_v) begin fails++; $display("FAIL bp_result got %h want %h", {cout, sum}, exp_v); end
      @(negedge clk);
      tests++; if ({in_ready, busy} !== 2'b10) begin fails++; $display("FAIL bp_release got %b want 10", {in_ready, busy}); end
      @(negedge clk);
      tests++; if ({in_ready, busy} !== 2'b10) begin fails++; $display("FAIL bp_ignored_latched got %b want 10", {in_ready, busy}); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      out_ready = 1'b1;
      send(8'h55, 8'h55, 1'b0);
      @(negedge clk); @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      sb.delete();
      tests++; if ({in_ready, out_valid, busy, cout, dp_ci} !== 5'b10000) begin fails++; $display("FAIL rstmid_ctl got %b want 10000", {in_ready, out_valid, busy, cout, dp_ci}); end
      tests++; if ({sum, dp_a, dp_b} !== 12'h000) begin fails++; $display("FAIL rstmid_data got %h want 000", {sum, dp_a, dp_b}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(8'h01, 8'h01, 1'b0);
      wait_valid(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rstmid_timeout got no out_valid want out_valid"); end
      exp_v = sb.pop_front();
      tests++; if ({cout, sum} !== exp_v) begin fails++; $display("FAIL rstmid_result got %h want %h", {cout, sum}, exp_v); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [7:0] pa[3] = '{8'h80, 8'h7F, 8'hAA};
      logic [7:0] pb[3] = '{8'h80, 8'h01, 8'h55};
      logic       pc[3] = '{1'b0, 1'b0, 1'b1};
      int         acc[3] = '{0, 0, 0};
      int         idx = 0, got = 0, cyc = 0;
      bit         adv = 1'b0;
      out_ready = 1'b1;
      a = pa[0]; b = pb[0]; cin = pc[0]; in_valid = 1'b1;
      while ((got < 3) && (cyc < 100)) begin
         if (adv) begin
            idx++; adv = 1'b0;
            if (idx < 3) begin a = pa[idx]; b = pb[idx]; cin = pc[idx]; end
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            exp_v = sb.pop_front(); got++;
            tests++; if ({cout, sum} !== exp_v) begin fails++; $display("FAIL b2b_result %0d got %h want %h", got, {cout, sum}, exp_v); end
         end
         if (in_valid && in_ready) begin
            sb.push_back({1'b0, a} + {1'b0, b} + {8'b0, cin});
            acc[idx] = cyc; adv = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      tests++; if (got !== 3) begin fails++; $display("FAIL b2b_timeout got %0d results want 3", got); end
      tests++; if (acc[1] - acc[0] !== 6) begin fails++; $display("FAIL b2b_gap01 got %0d want 6", acc[1] - acc[0]); end
      tests++; if (acc[2] - acc[1] !== 6) begin fails++; $display("FAIL b2b_gap12 got %0d want 6", acc[2] - acc[1]); end
   endtask

   task automatic test_operand_change;
      bit ok;
      out_ready = 1'b1;
      send(8'h3C, 8'h4B, 1'b1);
      for (int k = 0; k < 4; k++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         @(negedge clk);
      end
      wait_valid(ok);
      tests++; if (!ok) begin fails++; $display("FAIL opchg_timeout got no out_valid want out_valid"); end
      exp_v = sb.pop_front();
      tests++; if ({cout, sum} !== exp_v || exp_v !== 9'h088) begin fails++; $display("FAIL opchg_result got %h want %h", {cout, sum}, exp_v); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ripple();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_operand_change();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
